// File: rtl/board_marker_if.sv
// Bundles the board load, call handshake and mark/result signals of board_marker.
// Latency: none, pure wiring.
// Backpressure: call_valid/call_ready handshake; loads and clear have no backpressure.
interface board_marker_if #(
    parameter int NUM_W = 5
);
    logic             load_valid;
    logic [4:0]       load_idx;
    logic [NUM_W-1:0] load_num;
    logic             clear;
    logic             call_valid;
    logic [NUM_W-1:0] call_num;
    logic             call_ready;
    logic             done;
    logic             hit;
    logic [4:0]       hit_idx;
    logic [24:0]      circle;

    // Game controller side: drives loads, clear and calls; observes results.
    modport master (
        output load_valid, load_idx, load_num, clear, call_valid, call_num,
        input  call_ready, done, hit, hit_idx, circle
    );

    // Board side.
    modport slave (
        input  load_valid, load_idx, load_num, clear, call_valid, call_num,
        output call_ready, done, hit, hit_idx, circle
    );
endinterface

// File: rtl/board_marker.sv
// Holds a 5x5 Bingo board and marks the first cell equal to each called number (sequential scan).
// Latency: done 1 cycle after accept for a hit at cell 0, k+1 for cell k, 25 for no hit.
// Backpressure: call_ready only in IDLE; loads outside IDLE dropped; clear wins always. Option: BINGO_FREE_CENTER_EN.
module board_marker #(
    parameter int NUM_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    board_marker_if.slave bus
);

`ifdef BINGO_FREE_CENTER_EN
    // Cell 12 is a permanently marked free space that can be neither loaded nor matched.
    localparam logic FREE_CENTER = 1'b1;
`else
    localparam logic FREE_CENTER = 1'b0;
`endif
    localparam logic [24:0] CIRCLE_RST = FREE_CENTER ? 25'h0001000 : 25'h0000000;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state;
    logic [NUM_W-1:0] board [25];
    logic [NUM_W-1:0] num_q;
    logic [4:0]       idx;
    logic [24:0]      circle_q;
    logic             call_ready_q;
    logic             done_q;
    logic             hit_q;
    logic [4:0]       hit_idx_q;

    logic load_ok;
    logic cell_match;

    // Loads only land while idle, on a real cell, and never on the free space.
    assign load_ok = bus.load_valid && (state == IDLE) && (bus.load_idx < 5'd25)
                     && !(FREE_CENTER && (bus.load_idx == 5'd12));

    // Zero is an empty cell / empty call and never matches.
    assign cell_match = (num_q != '0) && (board[idx] == num_q)
                        && !(FREE_CENTER && (idx == 5'd12));

    // Board storage; clear leaves the numbers in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 25; i++) begin
                board[i] <= '0;
            end
        end else if (load_ok) begin
            board[bus.load_idx] <= bus.load_num;
        end
    end

    // Scan FSM with registered handshake, result and mark outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            num_q        <= '0;
            idx          <= '0;
            circle_q     <= CIRCLE_RST;
            call_ready_q <= 1'b1;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
        end else if (bus.clear) begin
            state        <= IDLE;
            circle_q     <= CIRCLE_RST;
            call_ready_q <= 1'b1;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.call_valid) begin
                        num_q        <= bus.call_num;
                        idx          <= '0;
                        call_ready_q <= 1'b0;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    if (cell_match) begin
                        circle_q[idx] <= 1'b1;
                        hit_q         <= 1'b1;
                        hit_idx_q     <= idx;
                        done_q        <= 1'b1;
                        state         <= DONE;
                    end else if (idx == 5'd24) begin
                        hit_q     <= 1'b0;
                        hit_idx_q <= '0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                DONE: begin
                    done_q       <= 1'b0;
                    call_ready_q <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.call_ready = call_ready_q;
    assign bus.done       = done_q;
    assign bus.hit        = hit_q;
    assign bus.hit_idx    = hit_idx_q;
    assign bus.circle     = circle_q;

endmodule

// File: tb/tb_board_marker.sv
// Randomized and directed bench for board_marker against a cycle-count reference model.
// Latency: model predicts done at accept + (k+1) or + 25 cycles.
// Backpressure: stimulus honours call_ready; random phase also fires calls/loads while busy.
module tb_board_marker;

`ifdef BINGO_FREE_CENTER_EN
    localparam logic        FREE_EN = 1'b1;
    localparam logic [24:0] FREE    = 25'h0001000;
`else
    localparam logic        FREE_EN = 1'b0;
    localparam logic [24:0] FREE    = 25'h0000000;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    board_marker_if #(.NUM_W(5)) bus ();

    board_marker #(.NUM_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [4:0]  mb [25];
    logic        m_ready, m_done, m_hit, m_busy, r_hit, was_idle;
    logic [4:0]  m_hidx, r_idx;
    logic [24:0] m_circ;
    int          rem;

    // Model advances on each edge: on accept it predicts the first matching cell and
    // the cycle count until the result appears.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 25; i++) mb[i] = '0;
            m_ready = 1'b1; m_done = 1'b0; m_hit = 1'b0; m_hidx = '0;
            m_circ = FREE; m_busy = 1'b0; rem = 0; r_hit = 1'b0; r_idx = '0;
        end else begin
            was_idle = m_ready;
            if (was_idle && bus.load_valid && bus.load_idx < 5'd25 &&
                !(FREE_EN && bus.load_idx == 5'd12))
                mb[bus.load_idx] = bus.load_num;
            if (bus.clear) begin
                m_circ = FREE; m_hit = 1'b0; m_hidx = '0;
                m_ready = 1'b1; m_done = 1'b0; m_busy = 1'b0;
            end else if (m_done) begin
                m_done = 1'b0; m_ready = 1'b1;
            end else if (m_busy) begin
                rem--;
                if (rem == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_hit = r_hit; m_hidx = r_idx;
                    if (r_hit) m_circ[r_idx] = 1'b1;
                end
            end else if (bus.call_valid) begin
                r_hit = 1'b0; r_idx = '0;
                for (int i = 0; i < 25; i++) begin
                    if (!r_hit && bus.call_num != 5'd0 && mb[i] == bus.call_num &&
                        !(FREE_EN && i == 12)) begin
                        r_hit = 1'b1; r_idx = 5'(i);
                    end
                end
                rem = r_hit ? int'(r_idx) + 1 : 25;
                m_busy = 1'b1; m_ready = 1'b0;
            end
        end
    end

    // Every cycle out of reset, all outputs must equal the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("call_ready", 32'(bus.call_ready), 32'(m_ready));
            chk("done",       32'(bus.done),       32'(m_done));
            chk("hit",        32'(bus.hit),        32'(m_hit));
            chk("hit_idx",    32'(bus.hit_idx),    32'(m_hidx));
            chk("circle",     32'(bus.circle),     32'(m_circ));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        int w = 0;
        while (!bus.call_ready && w < 50) begin @(negedge clk); w++; end
        if (!bus.call_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_load(input int idx, input int num);
        wait_ready();
        bus.load_valid = 1'b1; bus.load_idx = 5'(idx); bus.load_num = 5'(num);
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    task automatic do_call(input int num, output int lat, output int rdy_hi);
        wait_ready();
        bus.call_valid = 1'b1; bus.call_num = 5'(num);
        @(negedge clk);
        bus.call_valid = 1'b0;
        lat = 0; rdy_hi = 0;
        while (!bus.done && lat < 40) begin
            if (bus.call_ready) rdy_hi++;
            @(negedge clk);
            lat++;
        end
        if (!bus.done) chk("done_timeout", 0, 1);
    endtask

    int lat, rdy_hi;

    initial begin
        bus.load_valid = 1'b0; bus.load_idx = '0; bus.load_num = '0;
        bus.clear = 1'b0; bus.call_valid = 1'b0; bus.call_num = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready",  32'(bus.call_ready), 1);
        chk("rst_done",   32'(bus.done), 0);
        chk("rst_hit",    32'(bus.hit), 0);
        chk("rst_circle", 32'(bus.circle), 32'(FREE));

        for (int i = 0; i < 25; i++) do_load(i, i + 1);

        do_call(1, lat, rdy_hi);
        chk("c1_lat", lat, 1);
        chk("c1_hit", 32'(bus.hit), 1);
        chk("c1_idx", 32'(bus.hit_idx), 0);
        chk("c1_circle", 32'(bus.circle), 32'(25'h0000001 | FREE));

        do_call(25, lat, rdy_hi);
        chk("c25_lat", lat, 25);
        chk("c25_idx", 32'(bus.hit_idx), 24);
        chk("c25_rdy_low", rdy_hi, 0);
        chk("c25_circle", 32'(bus.circle), 32'(25'h1000001 | FREE));

        do_call(0, lat, rdy_hi);
        chk("c0_lat", lat, 25);
        chk("c0_hit", 32'(bus.hit), 0);
        chk("c0_idx", 32'(bus.hit_idx), 0);
        do_call(30, lat, rdy_hi);
        chk("c30_lat", lat, 25);
        chk("c30_hit", 32'(bus.hit), 0);
        chk("c30_circle", 32'(bus.circle), 32'(25'h1000001 | FREE));

        // Clear five cycles into a scan for 20.
        wait_ready();
        bus.call_valid = 1'b1; bus.call_num = 5'd20;
        @(negedge clk);
        bus.call_valid = 1'b0;
        repeat (5) begin chk("pre_clear_done", 32'(bus.done), 0); @(negedge clk); end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clr_done",   32'(bus.done), 0);
        chk("clr_circle", 32'(bus.circle), 32'(FREE));
        chk("clr_ready",  32'(bus.call_ready), 1);
        do_call(20, lat, rdy_hi);
        chk("c20_lat", lat, 20);
        chk("c20_idx", 32'(bus.hit_idx), 19);

        // Duplicates: lowest index wins, repeat call still hits.
        do_load(3, 9);
        do_load(7, 9);
        do_call(9, lat, rdy_hi);
        chk("dup1_idx", 32'(bus.hit_idx), 3);
        do_call(9, lat, rdy_hi);
        chk("dup2_hit", 32'(bus.hit), 1);
        chk("dup2_idx", 32'(bus.hit_idx), 3);
        chk("dup2_c7",  32'(bus.circle[7]), 0);

        // Centre cell: reloaded with 13; free space ignores both load and match.
        do_load(12, 13);
        do_call(13, lat, rdy_hi);
`ifdef BINGO_FREE_CENTER_EN
        chk("ctr_hit", 32'(bus.hit), 0);
        chk("ctr_lat", lat, 25);
`else
        chk("ctr_idx", 32'(bus.hit_idx), 12);
        chk("ctr_lat", lat, 13);
`endif

        // Random traffic with small number ranges to provoke duplicates and misses.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            bus.load_valid = ($urandom_range(0, 3) == 0);
            bus.load_idx   = 5'($urandom_range(0, 31));
            bus.load_num   = 5'($urandom_range(0, 7));
            bus.call_valid = ($urandom_range(0, 1) == 1);
            bus.call_num   = 5'($urandom_range(0, 9));
            bus.clear      = ($urandom_range(0, 59) == 0);
            if (c == 1200) begin
                rst_n = 1'b0;
                #2;
                chk("arst_ready",  32'(bus.call_ready), 1);
                chk("arst_circle", 32'(bus.circle), 32'(FREE));
                chk("arst_done",   32'(bus.done), 0);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        bus.load_valid = 1'b0; bus.call_valid = 1'b0; bus.clear = 1'b0;
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
